muldiv_unit: RTL and testbench

- Iterative unsigned multiply/divide unit placed beside the ALU in the execute stage.
- Consumes the two register-file read values: the dest-register value is operand A, the src-register value is operand B.
- Produces a one-cycle write-back (enable, address, data) that drives the register file's write port through the write-back mux.
- Multi-cycle: the core holds issue while busy is high.

---
 rtl/muldiv_unit.sv | 83 ++++++++
 tb/tb_muldiv_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned shift-add multiplier / restoring divider with register-file write-back
module muldiv_unit #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [D-1:0] dest_in,
  output logic         busy,
  output logic         wb_en,
  output logic [D-1:0] wb_addr,
  output logic [W-1:0] wb_data,
  output logic         div_zero
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(W + 1);
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_op;
  logic [W-1:0]  r_opnd, r_hi, r_lo, r_wb_data;
  logic [D-1:0]  r_dest, r_wb_addr;
  logic          r_div_zero;
  logic [W:0]    w_sum, w_shift;
  logic          w_ge;
  logic [W-1:0]  w_sub, w_next_hi, w_next_lo;
  // r_hi:r_lo is the product for MUL and remainder:quotient/dividend for DIV; the result is r_hi for odd ops
  always_comb begin
    w_sum     = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {W{1'b0}})};
    w_shift   = {r_hi, r_lo[W-1]};
    w_ge      = w_shift >= {1'b0, r_opnd};
    w_sub     = w_shift[W-1:0] - r_opnd;
    w_next_hi = r_op[1] ? (w_ge ? w_sub : w_shift[W-1:0]) : w_sum[W:1];
    w_next_lo = r_op[1] ? {r_lo[W-2:0], w_ge} : {w_sum[0], r_lo[W-1:1]};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_dest     <= '0;
      r_wb_data  <= '0;
      r_wb_addr  <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_op    <= op;
          r_opnd  <= op[1] ? b_in : a_in;
          r_hi    <= '0;
          r_lo    <= op[1] ? a_in : b_in;
          r_dest  <= dest_in;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: if (r_cnt == CW'(W)) begin
          r_state    <= DONE;
          r_wb_data  <= r_op[0] ? r_hi : r_lo;
          r_wb_addr  <= r_dest;
          r_div_zero <= r_op[1] && (r_opnd == '0);
        end else begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    busy     = r_state != IDLE;
    wb_en    = r_state == DONE;
    wb_addr  = r_wb_addr;
    wb_data  = r_wb_data;
    div_zero = r_div_zero;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and randomized checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  localparam int W = 8;
  localparam int D = 3;
  logic clk = 0, reset = 0, start = 0;
  logic [1:0] op = 0;
  logic [W-1:0] a_in = 0, b_in = 0;
  logic [D-1:0] dest_in = 0;
  logic busy, wb_en, div_zero;
  logic [D-1:0] wb_addr;
  logic [W-1:0] wb_data;
  int n_tests = 0, n_fail = 0;

  muldiv_unit #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .dest_in(dest_in), .busy(busy), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [D-1:0] dest;
    logic [W-1:0] exp;
    logic         dz;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = a * b;
    case (o)
      2'b00: return {1'b0, p[W-1:0]};
      2'b01: return {1'b0, p[2*W-1:W]};
      2'b10: return (b == 0) ? {1'b1, {W{1'b1}}} : {1'b0, a / b};
      default: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic [D-1:0] d_v, input bit scr, output logic [W-1:0] data,
                        output logic [D-1:0] addr, output logic dz, output int lat, output int pulses,
                        output logic busy0, output logic busy_end);
    @(negedge clk);
    start = 1; op = op_v; a_in = a_v; b_in = b_v; dest_in = d_v;
    @(posedge clk); #1;
    busy0 = busy; lat = -1; pulses = 0; data = 0; addr = 0; dz = 0; busy_end = 1;
    for (int k = 1; k <= W + 3; k++) begin
      start = (scr && k <= W + 1) ? 1'($urandom) : 1'b0;
      if (scr) begin
        op = 2'($urandom); a_in = W'($urandom); b_in = W'($urandom); dest_in = D'($urandom);
      end
      @(posedge clk); #1;
      if (wb_en) begin
        pulses++;
        if (lat < 0) begin
          lat = k; data = wb_data; addr = wb_addr; dz = div_zero;
        end
      end
      if (k == W + 2) busy_end = busy;
    end
  endtask

  task automatic check_op(input string tag, input logic [1:0] op_v, input logic [W-1:0] a_v,
                          input logic [W-1:0] b_v, input logic [D-1:0] d_v, input bit scr,
                          input logic [W-1:0] exp, input logic exp_dz);
    logic [W-1:0] data;
    logic [D-1:0] addr;
    logic dz, b0, be;
    int lat, pulses;
    run_op(op_v, a_v, b_v, d_v, scr, data, addr, dz, lat, pulses, b0, be);
    chk({tag, " data"}, 32'(data), 32'(exp));
    chk({tag, " addr"}, 32'(addr), 32'(d_v));
    chk({tag, " div_zero"}, 32'(dz), 32'(exp_dz));
    chk({tag, " latency"}, 32'(lat), 32'(W + 1));
    chk({tag, " pulses"}, 32'(pulses), 32'd1);
    chk({tag, " busy_start"}, 32'(b0), 32'd1);
    chk({tag, " busy_end"}, 32'(be), 32'd0);
  endtask

  initial begin
    logic [W:0] m;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    int cnt;
    tbl[0]  = '{2'b00, 8'd200, 8'd3,   3'd1, 8'h58, 1'b0};
    tbl[1]  = '{2'b01, 8'd200, 8'd3,   3'd2, 8'h02, 1'b0};
    tbl[2]  = '{2'b10, 8'd200, 8'd7,   3'd3, 8'h1C, 1'b0};
    tbl[3]  = '{2'b11, 8'd200, 8'd7,   3'd4, 8'h04, 1'b0};
    tbl[4]  = '{2'b10, 8'd5,   8'd9,   3'd5, 8'h00, 1'b0};
    tbl[5]  = '{2'b11, 8'd5,   8'd9,   3'd6, 8'h05, 1'b0};
    tbl[6]  = '{2'b10, 8'h5A,  8'd0,   3'd7, 8'hFF, 1'b1};
    tbl[7]  = '{2'b11, 8'h5A,  8'd0,   3'd1, 8'h5A, 1'b1};
    tbl[8]  = '{2'b00, 8'd255, 8'd255, 3'd2, 8'h01, 1'b0};
    tbl[9]  = '{2'b10, 8'd255, 8'd1,   3'd3, 8'hFF, 1'b0};
    tbl[10] = '{2'b11, 8'd0,   8'd0,   3'd4, 8'h00, 1'b1};
    tbl[11] = '{2'b01, 8'd255, 8'd255, 3'd6, 8'hFE, 1'b0};
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset wb_en", 32'(wb_en), 32'd0);
    chk("reset wb_data", 32'(wb_data), 32'd0);
    chk("reset wb_addr", 32'(wb_addr), 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    @(negedge clk); reset = 1;
    for (int i = 0; i < 12; i++) check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dest, 1'b0, tbl[i].exp, tbl[i].dz);
    for (int i = 0; i < 12; i++) check_op($sformatf("tbl%0d_scr", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dest, 1'b1, tbl[i].exp, tbl[i].dz);
    // abort mid-run: reset falls between edges 5 and 6 of a new operation
    @(negedge clk);
    start = 1; op = 2'b00; a_in = 8'd200; b_in = 8'd3; dest_in = 3'd5;
    @(posedge clk); #1; start = 0;
    repeat (5) @(posedge clk);
    #2; reset = 0; #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort wb_en", 32'(wb_en), 32'd0);
    chk("abort wb_data", 32'(wb_data), 32'd0);
    chk("abort wb_addr", 32'(wb_addr), 32'd0);
    chk("abort div_zero", 32'(div_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (wb_en) cnt++;
    end
    chk("abort no_wb", 32'(cnt), 32'd0);
    chk("abort idle", 32'(busy), 32'd0);
    check_op("after_abort", 2'b10, 8'd200, 8'd7, 3'd3, 1'b0, 8'h1C, 1'b0);
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
      m = model(rop, ra, rb);
      check_op($sformatf("rnd%0d", i), rop, ra, rb, D'($urandom), 1'(i % 2), m[W-1:0], m[W] & rop[1]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
